// File: rtl/lsu_mem_align_pkg.sv
// Shared constants for the LSU data-memory aligner: bus bit indices, stall
// encoding and the field layout of the MEM-stage response register.
package lsu_mem_align_pkg;

  localparam int STALL_W   = 6;
  localparam int LOAD_W    = 5;
  localparam int SAVE_W    = 3;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // {lb,lbu,lh,lhu,lw} and {sb,sh,sw}
  localparam int LB  = 4;
  localparam int LBU = 3;
  localparam int LH  = 2;
  localparam int LHU = 1;
  localparam int LW  = 0;
  localparam int SB  = 2;
  localparam int SH  = 1;
  localparam int SW  = 0;

  localparam int RESP_VLD      = 0;
  localparam int RESP_TYPE_LSB = RESP_VLD + 1;
  localparam int RESP_OFF_LSB  = RESP_TYPE_LSB + LOAD_W;
  localparam int RESP_ADEL     = RESP_OFF_LSB + 2;
  localparam int RESP_ADES     = RESP_ADEL + 1;
  localparam int RESP_ADDR_LSB = RESP_ADES + 1;

  function automatic int lsu_resp_wd(input int addr_w);
    return RESP_ADDR_LSB + addr_w;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Selects the addressed byte/half/word from a 32-bit read word and sign- or
// zero-extends it. Purely combinational.
module lsu_load_extract
  import lsu_mem_align_pkg::*;
(
  input  logic [LOAD_W-1:0] ltype,
  input  logic [1:0]        off,
  input  logic [31:0]       word,
  output logic [31:0]       data
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  always_comb begin
    b_sel = word[{off, 3'b000} +: 8];
    h_sel = off[1] ? word[31:16] : word[15:0];
    data  = '0;
    if (ltype[LB])       data = {{24{b_sel[7]}}, b_sel};
    else if (ltype[LBU]) data = {24'b0, b_sel};
    else if (ltype[LH])  data = {{16{h_sel[15]}}, h_sel};
    else if (ltype[LHU]) data = {16'b0, h_sel};
    else if (ltype[LW])  data = word;
  end

endmodule

// File: rtl/lsu_mem_align.sv
// EX-stage SRAM request generation plus MEM-stage load alignment; result is 1 cycle
// after the request, held across MEM stalls. Misalignment traps when LSU_ALIGN_EXCP_EN is defined.
module lsu_mem_align
  import lsu_mem_align_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALL_W-1:0] stall,
  input  logic              flush,
  input  logic [LOAD_W-1:0] ex_load_bus,
  input  logic [SAVE_W-1:0] ex_save_bus,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_sdata,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_wen,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic              mem_load_valid,
  output logic [DATA_W-1:0] mem_load_data,
  output logic              mem_excp_adel,
  output logic              mem_excp_ades,
  output logic [ADDR_W-1:0] mem_badvaddr
);

  localparam int LSU_RESP_WD = lsu_resp_wd(ADDR_W);

  logic [1:0] off;
  logic [1:0] off_eff;
  logic       single;
  logic       is_load;
  logic       is_store;
  logic       half_op;
  logic       word_op;
  logic       misalign;
  logic       ex_go;
  logic       access;

  assign off      = ex_addr[1:0];
  assign single   = ($countones({ex_load_bus, ex_save_bus}) == 1);
  assign is_load  = |ex_load_bus;
  assign is_store = |ex_save_bus;
  assign half_op  = ex_load_bus[LH] | ex_load_bus[LHU] | ex_save_bus[SH];
  assign word_op  = ex_load_bus[LW] | ex_save_bus[SW];
  assign ex_go    = (stall[STALL_EX] == NO_STOP);

`ifdef LSU_ALIGN_EXCP_EN
  assign misalign = single & ((half_op & off[0]) | (word_op & (off != 2'b00)));
  assign off_eff  = off;
`else
  // Without trapping, low address bits below the access size are ignored.
  assign misalign = 1'b0;
  assign off_eff  = word_op ? 2'b00 : (half_op ? {off[1], 1'b0} : off);
`endif

  assign access         = single & ~misalign & ~flush & ex_go & ~rst;
  assign data_sram_en   = access;
  assign data_sram_addr = rst ? '0 : {ex_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    data_sram_wen   = 4'b0000;
    data_sram_wdata = '0;
    if (!rst) begin
      if (ex_save_bus[SB])      data_sram_wdata = {4{ex_sdata[7:0]}};
      else if (ex_save_bus[SH]) data_sram_wdata = {2{ex_sdata[15:0]}};
      else if (ex_save_bus[SW]) data_sram_wdata = ex_sdata;
      if (access) begin
        if (ex_save_bus[SB])      data_sram_wen = 4'b0001 << off_eff;
        else if (ex_save_bus[SH]) data_sram_wen = off_eff[1] ? 4'b1100 : 4'b0011;
        else if (ex_save_bus[SW]) data_sram_wen = 4'b1111;
      end
    end
  end

  logic [LSU_RESP_WD-1:0] resp_d;
  logic [LSU_RESP_WD-1:0] resp_q;

  always_comb begin
    resp_d                              = '0;
    resp_d[RESP_VLD]                    = single & is_load;
    resp_d[RESP_TYPE_LSB +: LOAD_W]     = ex_load_bus;
    resp_d[RESP_OFF_LSB +: 2]           = off_eff;
    resp_d[RESP_ADEL]                   = misalign & is_load;
    resp_d[RESP_ADES]                   = misalign & is_store;
    resp_d[RESP_ADDR_LSB +: ADDR_W]     = ex_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q <= '0;
    end else if (flush) begin
      resp_q <= '0;
    end else if (stall[STALL_EX] == STOP && stall[STALL_MEM] == NO_STOP) begin
      resp_q <= '0;
    end else if (ex_go) begin
      resp_q <= resp_d;
    end
  end

  logic              resp_vld;
  logic              resp_adel;
  logic              resp_ades;
  logic              held;
  logic [DATA_W-1:0] rbuf;
  logic [DATA_W-1:0] rsrc;
  logic [31:0]       ext_data;

  assign resp_vld  = resp_q[RESP_VLD];
  assign resp_adel = resp_q[RESP_ADEL];
  assign resp_ades = resp_q[RESP_ADES];

  // SRAM output is only valid the cycle after the enable, so capture it once per stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= 1'b0;
      rbuf <= '0;
    end else if (flush || stall[STALL_MEM] == NO_STOP) begin
      held <= 1'b0;
    end else if (resp_vld && !held) begin
      held <= 1'b1;
      rbuf <= data_sram_rdata;
    end
  end

  assign rsrc = held ? rbuf : data_sram_rdata;

  lsu_load_extract u_extract (
    .ltype (resp_q[RESP_TYPE_LSB +: LOAD_W]),
    .off   (resp_q[RESP_OFF_LSB +: 2]),
    .word  (rsrc),
    .data  (ext_data)
  );

  assign mem_load_valid = resp_vld & ~resp_adel & ~resp_ades;
  assign mem_load_data  = mem_load_valid ? ext_data : '0;

`ifdef LSU_ALIGN_EXCP_EN
  assign mem_excp_adel = resp_adel;
  assign mem_excp_ades = resp_ades;
  assign mem_badvaddr  = (resp_adel | resp_ades) ? resp_q[RESP_ADDR_LSB +: ADDR_W] : '0;
`else
  logic unused_resp_addr;
  assign unused_resp_addr = ^resp_q[RESP_ADDR_LSB +: ADDR_W];
  assign mem_excp_adel    = 1'b0;
  assign mem_excp_ades    = 1'b0;
  assign mem_badvaddr     = '0;
`endif

  logic unused_stall;
  assign unused_stall = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_EX-1:0]};

endmodule

// File: tb/tb_lsu_mem_align.sv
// Bench for lsu_mem_align: directed scenarios plus randomized traffic checked
// against a behavioural model of the memory access rules.
module tb_lsu_mem_align;

`ifdef LSU_ALIGN_EXCP_EN
  localparam bit ALIGN_EXCP = 1'b1;
`else
  localparam bit ALIGN_EXCP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  load_bus;
  logic [2:0]  save_bus;
  logic [31:0] addr, sdata, rdata;
  logic        en, valid, adel, ades;
  logic [3:0]  wen;
  logic [31:0] sram_addr, wdata, ldata, bad;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu_mem_align dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_load_bus(load_bus), .ex_save_bus(save_bus), .ex_addr(addr), .ex_sdata(sdata),
    .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(sram_addr),
    .data_sram_wdata(wdata), .data_sram_rdata(rdata),
    .mem_load_valid(valid), .mem_load_data(ldata),
    .mem_excp_adel(adel), .mem_excp_ades(ades), .mem_badvaddr(bad)
  );

  typedef enum int {OP_NONE, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_MULTI} op_e;

  function automatic op_e decode(input logic [4:0] l, input logic [2:0] s);
    case ({l, s})
      8'b10000_000: return OP_LB;
      8'b01000_000: return OP_LBU;
      8'b00100_000: return OP_LH;
      8'b00010_000: return OP_LHU;
      8'b00001_000: return OP_LW;
      8'b00000_100: return OP_SB;
      8'b00000_010: return OP_SH;
      8'b00000_001: return OP_SW;
      8'b00000_000: return OP_NONE;
      default:      return OP_MULTI;
    endcase
  endfunction

  function automatic int sz(input op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit is_ld(input op_e op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic bit is_st(input op_e op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic bit mis(input op_e op, input logic [31:0] a);
    return ALIGN_EXCP && sz(op) > 1 && (a % sz(op)) != 0;
  endfunction

  function automatic int eoff(input op_e op, input logic [31:0] a);
    int o = int'(a % 4);
    if (!ALIGN_EXCP && sz(op) > 0) o = o - (o % sz(op));
    return o;
  endfunction

  function automatic logic [3:0] wen_f(input op_e op, input logic [31:0] a);
    int m;
    if (!is_st(op)) return 4'b0;
    m = ((1 << sz(op)) - 1) << eoff(op, a);
    return 4'(m);
  endfunction

  function automatic logic [31:0] wdata_f(input op_e op, input logic [31:0] d);
    longint unsigned unit, r;
    int s = sz(op);
    r = 0;
    if (s == 0) return 32'b0;
    unit = d & ((64'd1 << (8 * s)) - 1);
    for (int i = 0; i < 4 / s; i++) r |= unit << (8 * s * i);
    return r[31:0];
  endfunction

  function automatic logic [31:0] ld_f(input op_e op, input logic [31:0] a, input logic [31:0] w);
    longint unsigned mask, v;
    int s = sz(op);
    mask = (64'd1 << (8 * s)) - 1;
    v = w;
    v = (v >> (8 * eoff(op, a))) & mask;
    if ((op == OP_LB || op == OP_LH) && v[8 * s - 1]) v |= ~mask;
    return v[31:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] l, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    load_bus = l; save_bus = s; addr = a; sdata = d;
  endtask

  task automatic idle();
    drive(5'b0, 3'b0, 32'h0, 32'h0);
    stall = 6'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); rdata = 32'h1111_2222;
    drive(5'b00001, 3'b000, 32'h0000_1234, 32'h0);
    @(negedge clk);
    checks++; if (en !== 1'b0)   begin errors++; $display("FAIL reset_en got=%0h exp=0", en); end
    checks++; if (sram_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%0h exp=0", sram_addr); end
    checks++; if (valid !== 1'b0 || ldata !== 32'h0) begin errors++; $display("FAIL reset_load got=%0h/%0h exp=0/0", valid, ldata); end
    cyc();
    rst = 1'b0; idle();
    @(negedge clk);
    checks++; if (valid !== 1'b0 || adel !== 1'b0 || ades !== 1'b0) begin errors++; $display("FAIL reset_mem got=%0h%0h%0h exp=000", valid, adel, ades); end
    cyc();
  endtask

  task automatic test_store_byte();
    idle(); drive(5'b0, 3'b100, 32'h0000_1003, 32'h0000_00AB);
    @(negedge clk);
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL sb_en got=%0h exp=1", en); end
    checks++; if (wen !== 4'b1000) begin errors++; $display("FAIL sb_wen got=%b exp=1000", wen); end
    checks++; if (wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got=%0h exp=ababa bab", wdata); end
    checks++; if (sram_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr got=%0h exp=1000", sram_addr); end
    cyc(); idle();
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL sb_no_load got=%0h exp=0", valid); end
    cyc();
  endtask

  task automatic test_load_extend();
    idle(); drive(5'b10000, 3'b0, 32'h0000_2001, 32'h0);
    @(negedge clk);
    checks++; if (en !== 1'b1 || wen !== 4'b0) begin errors++; $display("FAIL lb_req got=%0h/%b exp=1/0000", en, wen); end
    cyc(); drive(5'b01000, 3'b0, 32'h0000_2001, 32'h0); rdata = 32'h1234_F0FF;
    @(negedge clk);
    checks++; if (valid !== 1'b1 || ldata !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb_data got=%0h/%0h exp=1/fffffff0", valid, ldata); end
    cyc(); drive(5'b00010, 3'b0, 32'h0000_2002, 32'h0);
    @(negedge clk);
    checks++; if (ldata !== 32'h0000_00F0) begin errors++; $display("FAIL lbu_data got=%0h exp=f0", ldata); end
    cyc(); idle();
    @(negedge clk);
    checks++; if (ldata !== 32'h0000_1234) begin errors++; $display("FAIL lhu_data got=%0h exp=1234", ldata); end
    cyc();
  endtask

  task automatic test_mem_stall();
    idle(); drive(5'b00001, 3'b0, 32'h0000_3000, 32'h0);
    cyc(); idle(); stall = 6'b011000; rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) rdata = 32'h0;
      @(negedge clk);
      checks++; if (valid !== 1'b1 || ldata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_hold%0d got=%0h/%0h exp=1/deadbeef", i, valid, ldata); end
      cyc();
    end
    stall = 6'b0;
    @(negedge clk);
    checks++; if (valid !== 1'b1 || ldata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_release got=%0h/%0h exp=1/deadbeef", valid, ldata); end
    cyc();
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stall_after got=%0h exp=0", valid); end
    cyc();
  endtask

  task automatic test_ex_stall();
    idle(); drive(5'b00001, 3'b0, 32'h0000_0044, 32'h0);
    cyc(); drive(5'b0, 3'b001, 32'h0000_0040, 32'h1357_9BDF); stall = 6'b001000; rdata = 32'h7;
    @(negedge clk);
    checks++; if (en !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL exst_first got=%0h/%0h exp=0/1", en, valid); end
    cyc();
    @(negedge clk);
    checks++; if (en !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL exst_bubble got=%0h/%0h exp=0/0", en, valid); end
    cyc(); stall = 6'b0;
    @(negedge clk);
    checks++; if (en !== 1'b1 || wen !== 4'b1111 || sram_addr !== 32'h40) begin errors++; $display("FAIL exst_issue got=%0h/%b/%0h exp=1/1111/40", en, wen, sram_addr); end
    cyc(); idle();
    @(negedge clk);
    checks++; if (en !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL exst_once got=%0h/%0h exp=0/0", en, valid); end
    cyc();
  endtask

  task automatic test_misalign();
    idle(); drive(5'b00001, 3'b0, 32'h0000_5002, 32'h0);
`ifdef LSU_ALIGN_EXCP_EN
    @(negedge clk);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL mis_lw_en got=%0h exp=0", en); end
    cyc(); drive(5'b0, 3'b010, 32'h0000_5001, 32'h0); rdata = 32'h89AB_CDEF;
    @(negedge clk);
    checks++; if (adel !== 1'b1 || bad !== 32'h5002 || valid !== 1'b0) begin errors++; $display("FAIL mis_adel got=%0h/%0h/%0h exp=1/5002/0", adel, bad, valid); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL mis_sh_en got=%0h exp=0", en); end
    cyc();
    drive(5'b00001, 3'b001, 32'h0000_5004, 32'h0);
    @(negedge clk);
    checks++; if (ades !== 1'b1 || adel !== 1'b0 || bad !== 32'h5001) begin errors++; $display("FAIL mis_ades got=%0h/%0h/%0h exp=1/0/5001", ades, adel, bad); end
`else
    @(negedge clk);
    checks++; if (en !== 1'b1 || sram_addr !== 32'h5000) begin errors++; $display("FAIL mis_lw_req got=%0h/%0h exp=1/5000", en, sram_addr); end
    cyc(); drive(5'b00001, 3'b001, 32'h0000_5004, 32'h0); rdata = 32'h89AB_CDEF;
    @(negedge clk);
    checks++; if (adel !== 1'b0 || valid !== 1'b1 || ldata !== 32'h89AB_CDEF) begin errors++; $display("FAIL mis_lw_data got=%0h/%0h/%0h exp=0/1/89abcdef", adel, valid, ldata); end
`endif
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL multi_en got=%0h exp=0", en); end
    cyc(); idle();
    @(negedge clk);
    checks++; if (valid !== 1'b0 || adel !== 1'b0 || ades !== 1'b0) begin errors++; $display("FAIL multi_resp got=%0h%0h%0h exp=000", valid, adel, ades); end
    cyc();
  endtask

  task automatic test_random(input int n);
    op_e         op, m_op;
    logic [31:0] m_addr, m_word, e_ld;
    bit          m_seen, s3, s4, single, e_en, e_exc;
    logic [7:0]  bus;
    int          k, sp;
    idle(); flush = 1'b1;
    cyc();
    m_op = OP_NONE; m_addr = 0; m_word = 0; m_seen = 0;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 11);
      if (k < 8)       bus = 8'd1 << k;
      else if (k == 8) bus = 8'd0;
      else if (k == 9) begin
        bus = 8'($urandom);
        while ($countones(bus) < 2) bus = 8'($urandom);
      end else         bus = 8'd1 << $urandom_range(0, 7);
      drive(bus[7:3], bus[2:0], $urandom, $urandom);
      rdata = $urandom;
      sp = $urandom_range(0, 7);
      s3 = (sp <= 1); s4 = (sp == 1);
      stall = {1'($urandom), s4, s3, 3'($urandom)};
      flush = ($urandom_range(0, 15) == 0);
      op = decode(load_bus, save_bus);
      single = (op != OP_NONE && op != OP_MULTI);
      e_en = single && !mis(op, addr) && !flush && !s3;
      @(negedge clk);
      checks++; if (en !== e_en) begin errors++; $display("FAIL rnd_en i=%0d got=%0h exp=%0h", i, en, e_en); end
      checks++; if (wen !== (e_en ? wen_f(op, addr) : 4'b0)) begin errors++; $display("FAIL rnd_wen i=%0d got=%b exp=%b", i, wen, e_en ? wen_f(op, addr) : 4'b0); end
      checks++; if (sram_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL rnd_addr i=%0d got=%0h exp=%0h", i, sram_addr, {addr[31:2], 2'b00}); end
      if (is_st(op)) begin
        checks++; if (wdata !== wdata_f(op, sdata)) begin errors++; $display("FAIL rnd_wdata i=%0d got=%0h exp=%0h", i, wdata, wdata_f(op, sdata)); end
      end
      e_exc = mis(m_op, m_addr);
      e_ld  = (is_ld(m_op) && !e_exc) ? ld_f(m_op, m_addr, m_seen ? m_word : rdata) : 32'h0;
      checks++; if (valid !== (is_ld(m_op) && !e_exc)) begin errors++; $display("FAIL rnd_valid i=%0d got=%0h exp=%0h", i, valid, is_ld(m_op) && !e_exc); end
      checks++; if (ldata !== e_ld) begin errors++; $display("FAIL rnd_data i=%0d got=%0h exp=%0h", i, ldata, e_ld); end
      checks++; if (adel !== (is_ld(m_op) && e_exc) || ades !== (is_st(m_op) && e_exc)) begin errors++; $display("FAIL rnd_excp i=%0d got=%0h%0h exp=%0h%0h", i, adel, ades, is_ld(m_op) && e_exc, is_st(m_op) && e_exc); end
      checks++; if (bad !== (e_exc ? m_addr : 32'h0)) begin errors++; $display("FAIL rnd_bad i=%0d got=%0h exp=%0h", i, bad, e_exc ? m_addr : 32'h0); end
      @(posedge clk);
      if (flush || (s3 && !s4)) m_op = OP_NONE;
      else if (!s3) begin
        m_op = single ? op : OP_NONE; m_addr = addr; m_seen = 0;
      end else if (!m_seen) begin
        m_word = rdata; m_seen = 1;
      end
      #1;
    end
    idle();
    cyc();
  endtask

  task automatic test_reset_mid_load();
    idle(); drive(5'b00001, 3'b0, 32'h0000_6000, 32'h0);
    cyc(); drive(5'b0, 3'b001, 32'h0000_6004, 32'h5555_AAAA); rdata = 32'hCAFE_F00D;
    #1;
    checks++; if (valid !== 1'b1 || ldata !== 32'hCAFE_F00D || en !== 1'b1) begin errors++; $display("FAIL rml_pre got=%0h/%0h/%0h exp=1/cafef00d/1", valid, ldata, en); end
    rst = 1'b1;
    #1;
    checks++; if (en !== 1'b0 || wen !== 4'b0 || sram_addr !== 32'h0 || wdata !== 32'h0) begin errors++; $display("FAIL rml_req got=%0h/%b/%0h/%0h exp=0", en, wen, sram_addr, wdata); end
    checks++; if (valid !== 1'b0 || ldata !== 32'h0 || adel !== 1'b0 || ades !== 1'b0 || bad !== 32'h0) begin errors++; $display("FAIL rml_mem got=%0h/%0h/%0h/%0h/%0h exp=0", valid, ldata, adel, ades, bad); end
    cyc(); rst = 1'b0; idle();
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rml_after got=%0h exp=0", valid); end
    cyc();
  endtask

  initial begin
    rst = 1'b1; rdata = 32'h0;
    idle();
    test_reset();
    test_store_byte();
    test_load_extend();
    test_mem_stall();
    test_ex_stall();
    test_misalign();
    test_random(400);
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
